hazard_fwd_ctrl: RTL and testbench

//  Unified hazard-detection / forwarding controller for the 5+-stage MIPS pipeline (IF,ID,EX,MEM1..MEMn,WB).

---
 rtl/cpu_pipe_pkg.sv | 21 ++
 rtl/hz_stage_track.sv | 27 ++
 rtl/hazard_fwd_ctrl.sv | 150 +++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared pipeline types and constants
// for the hazard/forwarding controller and its scoreboard
package cpu_pipe_pkg;

  localparam int MAX_AW      = 8;
  localparam int FWD_REGFILE = 0;
  localparam int STG_EX      = 0;
  localparam int STG_MEM1    = 1;

  typedef struct packed {
    logic              v;
    logic [MAX_AW-1:0] rd;
    logic              regwr;
    logic              memrd;
  } sb_entry_t;

  function automatic int depth_of(input int mem_lat);
    return mem_lat + 2;
  endfunction

endpackage

// File: rtl/hz_stage_track.sv
// hz_stage_track: in-flight producer scoreboard,
// EX at index 0 through WB at index DEPTH-1
module hz_stage_track
  import cpu_pipe_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  hold_i,
  input  logic                  bubble_i,
  input  sb_entry_t             ent_i,
  output sb_entry_t [DEPTH-1:0] sb_o
);

  // shift producers one stage per advance; a stall injects an empty slot
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sb_o <= '0;
    end else if (!hold_i) begin
      sb_o[STG_EX] <= bubble_i ? '0 : ent_i;
      for (int s = STG_EX + 1; s < DEPTH; s++)
        sb_o[s] <= sb_o[s-1];
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: stall, flush and forward-select control
// for the MIPS pipeline with MEM_LAT-cycle data memory
module hazard_fwd_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int MEM_LAT   = 1,
  parameter int ID_BRANCH = 1,
  parameter int SELW      = $clog2(depth_of(MEM_LAT) + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_rs_used_i,
  input  logic              id_rt_used_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwr_i,
  input  logic              id_memrd_i,
  input  logic              id_branch_i,
  input  logic              br_taken_i,
  input  logic              mem_busy_i,
  output logic              pc_write_o,
  output logic              ifid_hold_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic              pipe_hold_o,
  output logic [SELW-1:0]   ex_rs_sel_o,
  output logic [SELW-1:0]   ex_rt_sel_o,
  output logic [SELW-1:0]   id_rs_sel_o,
  output logic [SELW-1:0]   id_rt_sel_o,
  output logic [31:0]       stall_cnt_o
);

  localparam int   DEPTH = depth_of(MEM_LAT);
  localparam int   WB    = DEPTH - 1;
  localparam logic ID_BR = (ID_BRANCH != 0);

  typedef logic [MAX_AW-1:0] ra_t;

  sb_entry_t [DEPTH-1:0] sb;
  sb_entry_t             id_ent;
  ra_t                   rs_x;
  ra_t                   rt_x;
  ra_t                   ex_rs_q;
  ra_t                   ex_rt_q;
  logic                  hit;
  logic                  ld_stall;
  logic                  br_stall;
  logic                  stall;

  function automatic logic prod(input sb_entry_t e, input ra_t r);
    return e.v & e.regwr & (e.rd == r) & (r != '0);
  endfunction

  function automatic logic rdy(input sb_entry_t e, input int s);
    return !e.memrd || (s >= MEM_LAT + 1);
  endfunction

  // youngest matching producer wins, so scan oldest first
  function automatic logic [SELW-1:0] pick(
    input sb_entry_t [DEPTH-1:0] t,
    input ra_t                   r,
    input logic                  rdy_only
  );
    logic [SELW-1:0] sel;
    sel = SELW'(FWD_REGFILE);
    for (int s = WB; s >= STG_MEM1; s--)
      if (prod(t[s], r) && (!rdy_only || rdy(t[s], s)))
        sel = SELW'(s);
    return sel;
  endfunction

  assign rs_x = MAX_AW'(id_rs_i);
  assign rt_x = MAX_AW'(id_rt_i);

  // pack the ID instruction as a future producer
  always_comb begin
    id_ent       = '0;
    id_ent.v     = id_valid_i;
    id_ent.rd    = MAX_AW'(id_rd_i);
    id_ent.regwr = id_regwr_i;
    id_ent.memrd = id_memrd_i;
  end

  hz_stage_track #(
    .DEPTH (DEPTH)
  ) u_track (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .hold_i   (mem_busy_i),
    .bubble_i (stall),
    .ent_i    (id_ent),
    .sb_o     (sb)
  );

  // detect producers whose result is not ready when the ID consumer needs it
  always_comb begin
    ld_stall = 1'b0;
    br_stall = 1'b0;
    hit      = 1'b0;
    for (int s = STG_EX; s < DEPTH; s++) begin
      hit = (id_rs_used_i & prod(sb[s], rs_x)) |
            (id_rt_used_i & prod(sb[s], rt_x));
      if (hit && sb[s].memrd && (s <= MEM_LAT - 1))
        ld_stall = 1'b1;
      if (hit && (sb[s].memrd ? (s <= MEM_LAT) : (s == STG_EX)))
        br_stall = 1'b1;
    end
  end

  assign stall = id_valid_i & ~mem_busy_i &
                 (ld_stall | (ID_BR & id_branch_i & br_stall));

  assign pipe_hold_o   = mem_busy_i;
  assign pc_write_o    = start_i & ~stall & ~mem_busy_i;
  assign ifid_hold_o   = stall | mem_busy_i;
  assign idex_bubble_o = stall;
  assign ifid_flush_o  = br_taken_i & ~stall & ~mem_busy_i;

  assign ex_rs_sel_o = pick(sb, ex_rs_q, 1'b0);
  assign ex_rt_sel_o = pick(sb, ex_rt_q, 1'b0);

  assign id_rs_sel_o = (ID_BR && id_valid_i && id_rs_used_i) ?
                       pick(sb, rs_x, 1'b1) : '0;
  assign id_rt_sel_o = (ID_BR && id_valid_i && id_rt_used_i) ?
                       pick(sb, rt_x, 1'b1) : '0;

  // EX consumer sources follow the instruction into EX; a bubble reads nothing
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_rs_q <= '0;
      ex_rt_q <= '0;
    end else if (!mem_busy_i) begin
      ex_rs_q <= (id_valid_i && id_rs_used_i && !stall) ? rs_x : '0;
      ex_rt_q <= (id_valid_i && id_rt_used_i && !stall) ? rt_x : '0;
    end
  end

  // saturating stall-cycle counter
  always_ff @(posedge clk_i) begin
    if (!rst_i)
      stall_cnt_o <= '0;
    else if (stall && (stall_cnt_o != 32'hFFFF_FFFF))
      stall_cnt_o <= stall_cnt_o + 32'd1;
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: checks MEM_LAT=1 and MEM_LAT=3 controllers
// against an age-based in-flight instruction model
module tb_hazard_fwd_ctrl;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rs_used;
    logic       rt_used;
    logic [4:0] rd;
    logic       regwr;
    logic       memrd;
    logic       branch;
    logic       taken;
    logic       busy;
    logic       start;
  } in_t;

  typedef struct {
    int         inst;
    int         age;
    logic [4:0] rd;
    logic       regwr;
    logic       load;
  } rec_t;

  typedef struct {
    logic        pcw;
    logic        hold;
    logic        flush;
    logic        bub;
    logic        phold;
    logic [2:0]  exrs;
    logic [2:0]  exrt;
    logic [2:0]  idrs;
    logic [2:0]  idrt;
    logic [31:0] cnt;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  in_t  d1;
  in_t  d3;

  always #5 clk = ~clk;

  logic        p1_pcw, p1_hold, p1_flush, p1_bub, p1_phold;
  logic [1:0]  p1_exrs, p1_exrt, p1_idrs, p1_idrt;
  logic [31:0] p1_cnt;
  logic        p3_pcw, p3_hold, p3_flush, p3_bub, p3_phold;
  logic [2:0]  p3_exrs, p3_exrt, p3_idrs, p3_idrt;
  logic [31:0] p3_cnt;

  hazard_fwd_ctrl #(.REG_AW(5), .MEM_LAT(1), .ID_BRANCH(1)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(d1.start),
    .id_valid_i(d1.valid), .id_rs_i(d1.rs), .id_rt_i(d1.rt),
    .id_rs_used_i(d1.rs_used), .id_rt_used_i(d1.rt_used),
    .id_rd_i(d1.rd), .id_regwr_i(d1.regwr), .id_memrd_i(d1.memrd),
    .id_branch_i(d1.branch), .br_taken_i(d1.taken), .mem_busy_i(d1.busy),
    .pc_write_o(p1_pcw), .ifid_hold_o(p1_hold), .ifid_flush_o(p1_flush),
    .idex_bubble_o(p1_bub), .pipe_hold_o(p1_phold),
    .ex_rs_sel_o(p1_exrs), .ex_rt_sel_o(p1_exrt),
    .id_rs_sel_o(p1_idrs), .id_rt_sel_o(p1_idrt),
    .stall_cnt_o(p1_cnt)
  );

  hazard_fwd_ctrl #(.REG_AW(5), .MEM_LAT(3), .ID_BRANCH(1)) u3 (
    .clk_i(clk), .rst_i(rst), .start_i(d3.start),
    .id_valid_i(d3.valid), .id_rs_i(d3.rs), .id_rt_i(d3.rt),
    .id_rs_used_i(d3.rs_used), .id_rt_used_i(d3.rt_used),
    .id_rd_i(d3.rd), .id_regwr_i(d3.regwr), .id_memrd_i(d3.memrd),
    .id_branch_i(d3.branch), .br_taken_i(d3.taken), .mem_busy_i(d3.busy),
    .pc_write_o(p3_pcw), .ifid_hold_o(p3_hold), .ifid_flush_o(p3_flush),
    .idex_bubble_o(p3_bub), .pipe_hold_o(p3_phold),
    .ex_rs_sel_o(p3_exrs), .ex_rt_sel_o(p3_exrt),
    .id_rs_sel_o(p3_idrs), .id_rt_sel_o(p3_idrt),
    .stall_cnt_o(p3_cnt)
  );

  int          checks = 0;
  int          errors = 0;
  rec_t        fl[$];
  logic [4:0]  exrs[2] = '{default: 5'd0};
  logic [4:0]  exrt[2] = '{default: 5'd0};
  logic [31:0] mcnt[2] = '{default: 32'd0};
  bit          mst[2]  = '{default: 1'b0};

  function automatic in_t din(input int i);
    return (i != 0) ? d3 : d1;
  endfunction

  function automatic int lat(input int i);
    return (i != 0) ? 3 : 1;
  endfunction

  // stage index from which a producer's result can be forwarded
  function automatic int ready_at(input rec_t p, input int l);
    return p.load ? l + 1 : 1;
  endfunction

  function automatic bit writes(input rec_t p, input logic [4:0] r);
    return p.regwr && (r != 5'd0) && (p.rd == r);
  endfunction

  function automatic bit m_stall(input int i);
    in_t d;
    int  l;
    bit  st;
    bit  hit;
    d  = din(i);
    l  = lat(i);
    st = 1'b0;
    if (!d.valid || d.busy) return 1'b0;
    foreach (fl[k]) begin
      if (fl[k].inst == i) begin
        hit = (d.rs_used && writes(fl[k], d.rs)) ||
              (d.rt_used && writes(fl[k], d.rt));
        // ALU consumer meets the producer one stage older next cycle
        if (hit && (fl[k].age + 1 < ready_at(fl[k], l))) st = 1'b1;
        // branch compares now, in ID
        if (hit && d.branch && (fl[k].age < ready_at(fl[k], l))) st = 1'b1;
      end
    end
    return st;
  endfunction

  function automatic int m_sel(input int i, input logic [4:0] r, input bit rdy_only);
    int best;
    best = 0;
    foreach (fl[k]) begin
      if (fl[k].inst == i && fl[k].age >= 1 && writes(fl[k], r) &&
          (!rdy_only || fl[k].age >= ready_at(fl[k], lat(i))))
        if (best == 0 || fl[k].age < best) best = fl[k].age;
    end
    return best;
  endfunction

  function automatic void model_step(input int i);
    in_t  d;
    rec_t nq[$];
    rec_t r;
    int   l;
    d = din(i);
    l = lat(i);
    if (!rst) begin
      foreach (fl[k]) if (fl[k].inst != i) nq.push_back(fl[k]);
      fl      = nq;
      exrs[i] = 5'd0;
      exrt[i] = 5'd0;
      mcnt[i] = 32'd0;
      return;
    end
    if (d.busy) return;
    foreach (fl[k]) begin
      r = fl[k];
      if (r.inst == i) begin
        r.age++;
        if (r.age < l + 2) nq.push_back(r);
      end else begin
        nq.push_back(r);
      end
    end
    if (d.valid && !mst[i]) begin
      r.inst  = i;
      r.age   = 0;
      r.rd    = d.rd;
      r.regwr = d.regwr;
      r.load  = d.memrd;
      nq.push_back(r);
    end
    fl      = nq;
    exrs[i] = (d.valid && d.rs_used && !mst[i]) ? d.rs : 5'd0;
    exrt[i] = (d.valid && d.rt_used && !mst[i]) ? d.rt : 5'd0;
    if (mst[i] && mcnt[i] != 32'hFFFF_FFFF) mcnt[i]++;
  endfunction

  function automatic out_t get_out(input int i);
    out_t o;
    if (i != 0) begin
      o = '{p3_pcw, p3_hold, p3_flush, p3_bub, p3_phold,
            p3_exrs, p3_exrt, p3_idrs, p3_idrt, p3_cnt};
    end else begin
      o = '{p1_pcw, p1_hold, p1_flush, p1_bub, p1_phold,
            3'(p1_exrs), 3'(p1_exrt), 3'(p1_idrs), 3'(p1_idrt), p1_cnt};
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic eval();
    #3;
    for (int i = 0; i < 2; i++) begin
      in_t   d;
      out_t  o;
      string n;
      logic  e;
      logic [4:0] ra;
      d = din(i);
      o = get_out(i);
      n = (i != 0) ? "L3" : "L1";
      mst[i] = m_stall(i);
      e = d.start & ~mst[i] & ~d.busy;
      chk({n, ".pc_write"}, 32'(o.pcw), 32'(e));
      e = mst[i] | d.busy;
      chk({n, ".ifid_hold"}, 32'(o.hold), 32'(e));
      e = d.taken & ~mst[i] & ~d.busy;
      chk({n, ".ifid_flush"}, 32'(o.flush), 32'(e));
      e = mst[i];
      chk({n, ".idex_bubble"}, 32'(o.bub), 32'(e));
      e = d.busy;
      chk({n, ".pipe_hold"}, 32'(o.phold), 32'(e));
      chk({n, ".ex_rs_sel"}, 32'(o.exrs), 32'(m_sel(i, exrs[i], 1'b0)));
      chk({n, ".ex_rt_sel"}, 32'(o.exrt), 32'(m_sel(i, exrt[i], 1'b0)));
      ra = (d.valid && d.rs_used) ? d.rs : 5'd0;
      chk({n, ".id_rs_sel"}, 32'(o.idrs), 32'(m_sel(i, ra, 1'b1)));
      ra = (d.valid && d.rt_used) ? d.rt : 5'd0;
      chk({n, ".id_rt_sel"}, 32'(o.idrt), 32'(m_sel(i, ra, 1'b1)));
      chk({n, ".stall_cnt"}, o.cnt, mcnt[i]);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    #1;
  endtask

  function automatic in_t nop();
    in_t d;
    d       = '0;
    d.start = 1'b1;
    return d;
  endfunction

  function automatic in_t alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    in_t d;
    d         = nop();
    d.valid   = 1'b1;
    d.rd      = rd;
    d.rs      = rs;
    d.rt      = rt;
    d.rs_used = 1'b1;
    d.rt_used = 1'b1;
    d.regwr   = 1'b1;
    return d;
  endfunction

  function automatic in_t lw(input logic [4:0] rd);
    in_t d;
    d         = nop();
    d.valid   = 1'b1;
    d.rd      = rd;
    d.rs_used = 1'b1;
    d.regwr   = 1'b1;
    d.memrd   = 1'b1;
    return d;
  endfunction

  function automatic in_t beq(input logic [4:0] rs, input logic [4:0] rt, input logic tk);
    in_t d;
    d         = nop();
    d.valid   = 1'b1;
    d.rs      = rs;
    d.rt      = rt;
    d.rs_used = 1'b1;
    d.rt_used = 1'b1;
    d.branch  = 1'b1;
    d.taken   = tk;
    return d;
  endfunction

  function automatic in_t rnd();
    in_t d;
    d         = nop();
    d.valid   = ($urandom_range(0, 9) < 8);
    d.rs      = 5'($urandom_range(0, 7));
    d.rt      = 5'($urandom_range(0, 7));
    d.rs_used = 1'($urandom_range(0, 1));
    d.rt_used = 1'($urandom_range(0, 1));
    d.rd      = 5'($urandom_range(0, 7));
    d.regwr   = ($urandom_range(0, 9) < 7);
    d.memrd   = d.regwr && ($urandom_range(0, 9) < 3);
    d.branch  = ($urandom_range(0, 4) == 0);
    d.taken   = ($urandom_range(0, 4) == 0);
    d.busy    = ($urandom_range(0, 9) == 0);
    d.start   = ($urandom_range(0, 9) != 0);
    return d;
  endfunction

  initial begin
    d1  = nop();
    d3  = nop();
    rst = 1'b0;
    @(posedge clk);
    #1;
    eval();
    chk("reset.cnt1", p1_cnt, 32'd0);
    chk("reset.exrs3", 32'(p3_exrs), 32'd0);
    chk("reset.pcw1", 32'(p1_pcw), 32'd1);
    adv();
    rst = 1'b1;
    eval(); adv();

    // lw $2 ; add $3,$2,$4 on MEM_LAT=1
    d1 = lw(5'd2);
    eval(); adv();
    d1 = alu(5'd3, 5'd2, 5'd4);
    eval();
    chk("L1.lu_bubble", 32'(p1_bub), 32'd1);
    chk("L1.lu_pcw", 32'(p1_pcw), 32'd0);
    adv();
    eval();
    chk("L1.lu_nostall", 32'(p1_bub), 32'd0);
    adv();
    d1 = nop();
    eval();
    chk("L1.lu_exrs", 32'(p1_exrs), 32'd2);
    chk("L1.lu_cnt", p1_cnt, 32'd1);
    adv();

    // lw $5 ; sub $6,$5,$5 on MEM_LAT=3
    d3 = lw(5'd5);
    eval(); adv();
    d3 = alu(5'd6, 5'd5, 5'd5);
    for (int k = 0; k < 3; k++) begin
      eval();
      chk("L3.lu_bubble", 32'(p3_bub), 32'd1);
      adv();
    end
    eval();
    chk("L3.lu_nostall", 32'(p3_bub), 32'd0);
    adv();
    d3 = nop();
    eval();
    chk("L3.lu_exrs", 32'(p3_exrs), 32'd4);
    chk("L3.lu_exrt", 32'(p3_exrt), 32'd4);
    chk("L3.lu_cnt", p3_cnt, 32'd3);
    adv();

    // add $1 ; add $1 ; or $7,$1,$1 -> youngest wins
    d1 = alu(5'd1, 5'd0, 5'd0);
    eval(); adv();
    eval(); adv();
    d1 = alu(5'd7, 5'd1, 5'd1);
    eval();
    chk("L1.yng_nostall", 32'(p1_bub), 32'd0);
    adv();
    d1 = nop();
    eval();
    chk("L1.yng_exrs", 32'(p1_exrs), 32'd1);
    chk("L1.yng_exrt", 32'(p1_exrt), 32'd1);
    adv();

    // rd=$0 producer never forwards
    d1 = alu(5'd0, 5'd0, 5'd0);
    eval(); adv();
    d1 = alu(5'd7, 5'd0, 5'd0);
    eval(); adv();
    d1 = nop();
    eval();
    chk("L1.zero_exrs", 32'(p1_exrs), 32'd0);
    adv();
    eval(); adv();

    // add $8 ; beq $8,$9 (taken) with ID compare
    d1 = alu(5'd8, 5'd0, 5'd0);
    eval(); adv();
    d1 = beq(5'd8, 5'd9, 1'b1);
    eval();
    chk("L1.br_bubble", 32'(p1_bub), 32'd1);
    chk("L1.br_noflush", 32'(p1_flush), 32'd0);
    adv();
    eval();
    chk("L1.br_idrs", 32'(p1_idrs), 32'd1);
    chk("L1.br_flush", 32'(p1_flush), 32'd1);
    adv();

    // taken branch under memory busy
    d1       = nop();
    d1.taken = 1'b1;
    d1.busy  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      eval();
      chk("L1.busy_hold", 32'(p1_phold), 32'd1);
      chk("L1.busy_noflush", 32'(p1_flush), 32'd0);
      chk("L1.busy_nopcw", 32'(p1_pcw), 32'd0);
      adv();
    end
    d1.busy = 1'b0;
    eval();
    chk("L1.busy_flush", 32'(p1_flush), 32'd1);
    adv();
    d1 = nop();

    // reset in the middle of a load stall
    d3 = lw(5'd5);
    eval(); adv();
    d3 = alu(5'd6, 5'd5, 5'd0);
    eval(); adv();
    rst = 1'b0;
    eval(); adv();
    rst = 1'b1;
    eval();
    chk("L3.rst_nostall", 32'(p3_bub), 32'd0);
    chk("L3.rst_cnt", p3_cnt, 32'd0);
    chk("L3.rst_exrs", 32'(p3_exrs), 32'd0);
    chk("L3.rst_idrs", 32'(p3_idrs), 32'd0);
    adv();

    // randomized traffic on both controllers
    for (int c = 0; c < 800; c++) begin
      d1  = rnd();
      d3  = rnd();
      rst = ($urandom_range(0, 59) != 0);
      eval();
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
